// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the unified memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
endpackage

// File: rtl/load_extend.sv
// load_extend: size selection and sign/zero extension of raw right-aligned load data.
module load_extend
  import mem_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    size,
  input  logic          is_unsigned,
  input  logic [DW-1:0] raw,
  output logic [DW-1:0] data
);
  logic sb, sh;
  always_comb begin
    sb = !is_unsigned && raw[7];
    sh = !is_unsigned && raw[15];
    data = size == SZ_BYTE ? {{(DW-8){sb}}, raw[7:0]}
         : size == SZ_HALF ? {{(DW-16){sh}}, raw[15:0]} : raw;
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between fetch and load/store, strict D priority.
// Define MEM_ARB_FAIRNESS_EN to force an IF grant after STARVE_MAX consecutive D grants.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef MEM_ARB_FAIRNESS_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic          d_unsigned,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  state_t        state;
  owner_t        owner;
  logic          cap_uns;
  logic          force_if;
  logic [DW-1:0] ext_data;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  assign force_if = if_req && starve_cnt == CW'(STARVE_MAX);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt <= '0;
    else if (if_gnt) starve_cnt <= '0;
    else if (d_gnt && if_req) starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign force_if = 1'b0;
`endif
  assign d_gnt = state == IDLE && d_req && !force_if;
  assign if_gnt = state == IDLE && if_req && (!d_req || force_if);
  assign if_stall = if_req && !if_rvalid;
  assign d_stall = d_req && !d_rvalid;
  load_extend #(.DW(DW)) u_ext (
    .size(mem_size),
    .is_unsigned(cap_uns),
    .raw(mem_rdata),
    .data(ext_data)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= OWN_IF;
      cap_uns <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_size <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: if (d_gnt || if_gnt) begin
          state <= BUSY;
          owner <= d_gnt ? OWN_D : OWN_IF;
          cap_uns <= d_unsigned;
          mem_en <= 1'b1;
          mem_we <= d_gnt && d_we;
          mem_size <= d_gnt && d_size != 2'b11 ? d_size : SZ_WORD;
          mem_addr <= d_gnt ? d_addr : if_addr;
          mem_wdata <= d_gnt ? d_wdata : '0;
        end
        BUSY: if (mem_ready) begin
          state <= RESP;
          mem_en <= 1'b0;
          if (owner == OWN_D) begin
            d_rvalid <= 1'b1;
            d_rdata <= mem_we ? '0 : ext_data;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: vector table plus corner sequences, responses checked through a scoreboard.
module tb_unified_mem_arbiter;
  typedef struct {
    bit          is_d;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] raw;
    int          lat;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 0, reset = 0;
  logic if_req = 0, d_req = 0, d_we = 0, d_unsigned = 0;
  logic [1:0] d_size = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_rvalid, if_stall, d_gnt, d_rvalid, d_stall;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic mem_en, mem_we, mem_ready;
  logic [1:0] mem_size;
  logic rdy = 0, force_rdy = 0;
  int lat = 0, wcnt = 0, cyc = 0;
  int vectors = 0, errs = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vt[12];

  unified_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_ready = rdy | force_rdy;

  // memory model: completes after `lat` wait cycles of a held command
  always @(negedge clk) begin
    if (!mem_en) begin
      wcnt <= 0;
      rdy <= 1'b0;
    end else begin
      rdy <= wcnt == lat;
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (if_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_rvalid: if_rvalid=%b d_rvalid=%b cycle %0d", if_rvalid, d_rvalid, cyc);
      end else begin
        e = sb.pop_front();
        chk("rv_both", 32'(if_rvalid & d_rvalid), 0);
        chk("rv_owner", 32'(d_rvalid), 32'(e.is_d));
        chk("rv_data", e.is_d ? d_rdata : if_rdata, e.data);
        chk("rv_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      #2;
      k++;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic apply(input vec_t v);
    int k;
    logic g;
    @(negedge clk);
    lat = v.lat;
    mem_rdata = v.raw;
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_size = v.size; d_unsigned = v.uns; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    #1;
    k = 0;
    while (!(v.is_d ? d_gnt : if_gnt) && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    g = v.is_d ? d_gnt : if_gnt;
    chk("gnt", 32'(g), 1);
    if (g) sb.push_back('{v.is_d, v.exp, cyc + 2 + v.lat});
    @(posedge clk);
    #1;
    d_req = 0;
    if_req = 0;
    for (int i = 0; i <= v.lat; i++) begin
      chk("mem_en", 32'(mem_en), 1);
      chk("mem_we", 32'(mem_we), 32'(v.is_d & v.we));
      chk("mem_addr", mem_addr, v.addr);
      if (v.size != 2'd3) chk("mem_size", 32'(mem_size), v.is_d ? 32'(v.size) : 2);
      if (v.is_d && v.we) chk("mem_wdata", mem_wdata, v.wdata);
      if (i < v.lat) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
  endtask

  task automatic run_reset_abort();
    @(negedge clk);
    lat = 5; mem_rdata = 32'h0000_5555;
    d_req = 1; d_we = 0; d_size = 2'd2; d_unsigned = 0; d_addr = 32'h100;
    #1;
    chk("ra_gnt", 32'(d_gnt), 1);
    @(posedge clk);
    #1;
    d_req = 0;
    chk("ra_busy_en", 32'(mem_en), 1);
    #2 reset = 0;
    #1;
    chk("ra_en_drop", 32'(mem_en), 0);
    chk("ra_no_drvalid", 32'(d_rvalid), 0);
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("ra_idle_en", 32'(mem_en), 0);
    lat = 0;
    d_req = 1;
    #1;
    chk("ra_regnt", 32'(d_gnt), 1);
    if (d_gnt) sb.push_back('{1'b1, 32'h0000_5555, cyc + 2});
    @(posedge clk);
    #1;
    d_req = 0;
    drain();
  endtask

  task automatic run_simultaneous();
    @(negedge clk);
    lat = 0; mem_rdata = 32'h1111_2222;
    d_req = 1; d_we = 0; d_size = 2'd2; d_unsigned = 0; d_addr = 32'h100;
    if_req = 1; if_addr = 32'h48;
    #1;
    chk("sim_d_gnt", 32'(d_gnt), 1);
    chk("sim_if_gnt0", 32'(if_gnt), 0);
    if (d_gnt) sb.push_back('{1'b1, 32'h1111_2222, cyc + 2});
    @(posedge clk);
    #1;
    d_req = 0;
    @(negedge clk);
    #1;
    chk("sim_busy_if_gnt", 32'(if_gnt), 0);
    chk("sim_if_stall", 32'(if_stall), 1);
    @(negedge clk);
    #1;
    chk("sim_resp_drvalid", 32'(d_rvalid), 1);
    chk("sim_resp_if_gnt", 32'(if_gnt), 0);
    mem_rdata = 32'h0000_0013;
    @(negedge clk);
    #1;
    chk("sim_if_gnt", 32'(if_gnt), 1);
    if (if_gnt) sb.push_back('{1'b0, 32'h0000_0013, cyc + 2});
    @(posedge clk);
    #1;
    if_req = 0;
    drain();
  endtask

  task automatic run_fairness();
    int k, cnt;
    logic exp_if;
    cnt = 0;
    @(negedge clk);
    lat = 0; mem_rdata = 32'h0000_0013;
    d_req = 1; d_we = 0; d_size = 2'd2; d_unsigned = 0; d_addr = 32'h300;
    if_req = 1; if_addr = 32'h4C;
    for (int n = 0; n < 12; n++) begin
      #1;
      k = 0;
      while (!(d_gnt || if_gnt) && k < 10) begin
        @(negedge clk);
        #1;
        k++;
      end
`ifdef MEM_ARB_FAIRNESS_EN
      exp_if = cnt == 4;
`else
      exp_if = 1'b0;
`endif
      chk("fair_if_gnt", 32'(if_gnt), 32'(exp_if));
      chk("fair_d_gnt", 32'(d_gnt), 32'(!exp_if));
      cnt = exp_if ? 0 : cnt + 1;
      if (d_gnt || if_gnt) sb.push_back('{d_gnt, 32'h0000_0013, cyc + 2});
      @(negedge clk);
    end
    d_req = 0;
    if_req = 0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h0050_0093, 0, 32'h0050_0093};
    vt[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h203,  32'h0,        32'h0000_0080, 0, 32'hFFFF_FF80};
    vt[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h203,  32'h0,        32'h0000_0080, 0, 32'h0000_0080};
    vt[3]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h8001, 32'h0,        32'h0000_8001, 0, 32'hFFFF_8001};
    vt[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h100,  32'h0,        32'h1234_8001, 1, 32'h0000_8001};
    vt[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h100,  32'h0,        32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    vt[6]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h104,  32'h0,        32'h8765_4321, 0, 32'h8765_4321};
    vt[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h10,   32'hDEAD_BEEF, 32'h1234_5678, 3, 32'h0};
    vt[8]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h11,   32'h0000_00AB, 32'hFFFF_FFFF, 1, 32'h0};
    vt[9]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h20,   32'h0,        32'hFFFF_7FFF, 0, 32'h0000_7FFF};
    vt[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h21,   32'h0,        32'hFFFF_FF7F, 0, 32'h0000_007F};
    vt[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h44,   32'h0,        32'hFFFF_FFFF, 2, 32'hFFFF_FFFF};
    repeat (2) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_size", 32'(mem_size), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    reset = 1;
    run_reset_abort();
    for (int i = 0; i < 12; i++) apply(vt[i]);
    run_simultaneous();
    @(negedge clk);
    force_rdy = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("stray_ready_en", 32'(mem_en), 0);
    force_rdy = 0;
    run_fairness();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
